// File: rtl/stop_watch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer: state encoding,
// debounce default and the counter timebase, so all blocks agree on one set.
package stop_watch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // 40 ms of stable level at 50 MHz before a button change is believed.
    localparam int DB_TICKS_DEFAULT = 2_000_000;

    // Counter timebase: one 0.1 s count every DVSR cycles of the 50 MHz clock.
    localparam int CLK_HZ = 50_000_000;
    localparam int DVSR   = CLK_HZ / 10;

    typedef struct packed {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd3_t;

    function automatic logic state_counts(input sw_state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stop_watch_ctrl_debounce.sv
// Per-button debouncer: two-FF synchronizer plus a stability counter; emits a
// one-cycle tick on every accepted press (0->1) and nothing on release.
module btn_debounce
    import stop_watch_ctrl_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic tick
);

    localparam int CW = $clog2(DB_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          tick_q;
    logic          tick_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter measures how long the synchronized input has disagreed
    // with the accepted level; any agreement restarts the measurement.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            tick_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign level = level_q;
    assign tick  = tick_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control sequencer: debounced buttons drive the IDLE/RUN/PAUSE/LAP
// FSM, which enables/clears the counter and freezes split digits for display.
module stop_watch_ctrl
    import stop_watch_ctrl_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    input  logic [3:0] d2_in,
    input  logic [3:0] d1_in,
    input  logic [3:0] d0_in,
    output logic       go,
    output logic       clr,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d0,
    output logic       lap_active,
    output logic [1:0] state
);

    logic       ss_tick;
    logic       clr_tick;
    logic       lap_tick;
    logic [2:0] unused_levels;

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_ss (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_ss),
        .level  (unused_levels[0]),
        .tick   (ss_tick)
    );

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_clr (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_clr),
        .level  (unused_levels[1]),
        .tick   (clr_tick)
    );

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_lap (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_lap),
        .level  (unused_levels[2]),
        .tick   (lap_tick)
    );

    sw_state_e state_q;
    logic      go_q;
    logic      clr_q;
    logic      lap_active_q;
    bcd3_t     lap_q;
    bcd3_t     live;

    assign live = '{d2: d2_in, d1: d1_in, d0: d0_in};

    // Each branch tests ticks in clr > ss > lap order, considering only the
    // ticks that mean something in that state; the rest are dropped.
    // clr stays high through reset so the reset-less counter is zeroed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            go_q         <= 1'b0;
            clr_q        <= 1'b1;
            lap_active_q <= 1'b0;
            lap_q        <= '0;
        end else begin
            clr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_tick) begin
                        clr_q <= 1'b1;
                    end else if (ss_tick) begin
                        state_q <= ST_RUN;
                        go_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ss_tick) begin
                        state_q <= ST_PAUSE;
                        go_q    <= 1'b0;
                    end else if (lap_tick) begin
                        state_q      <= ST_LAP;
                        lap_active_q <= 1'b1;
                        lap_q        <= live;
                    end
                end
                ST_LAP: begin
                    if (ss_tick) begin
                        state_q      <= ST_PAUSE;
                        go_q         <= 1'b0;
                        lap_active_q <= 1'b0;
                    end else if (lap_tick) begin
                        state_q      <= ST_RUN;
                        lap_active_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (clr_tick) begin
                        state_q <= ST_IDLE;
                        clr_q   <= 1'b1;
                    end else if (ss_tick) begin
                        state_q <= ST_RUN;
                        go_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    go_q         <= 1'b0;
                    lap_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Live digits bypass any register so the display tracks the counter.
    assign {disp_d2, disp_d1, disp_d0} = lap_active_q ? lap_q : live;

    assign go         = go_q;
    assign clr        = clr_q;
    assign lap_active = lap_active_q;
    assign state      = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl with DB_TICKS=4: directed scenarios followed by
// random button/reset/digit traffic, all checked each cycle against a model.
module tb_stop_watch_ctrl;

    localparam int DB = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

    logic       clk;
    logic       reset;
    logic       btn_ss, btn_clr, btn_lap;
    logic [3:0] d2_in, d1_in, d0_in;
    logic       go, clr, lap_active;
    logic [3:0] disp_d2, disp_d1, disp_d0;
    logic [1:0] dut_state;

    stop_watch_ctrl #(.DB_TICKS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_clr   (btn_clr),
        .btn_lap   (btn_lap),
        .d2_in     (d2_in),
        .d1_in     (d1_in),
        .d0_in     (d0_in),
        .go        (go),
        .clr       (clr),
        .disp_d2   (disp_d2),
        .disp_d1   (disp_d1),
        .disp_d0   (disp_d0),
        .lap_active(lap_active),
        .state     (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    // Reference model: buttons indexed 0=ss, 1=clr, 2=lap.
    int   m_state;
    bit   m_clr;
    logic [11:0] m_lap;
    bit   raw_hist[3][$];
    int   m_lvl[3];
    int   m_run[3];
    bit   m_tick[3];

    task automatic model_edge();
        bit raw_now[3];
        int win;
        raw_now[0] = btn_ss;
        raw_now[1] = btn_clr;
        raw_now[2] = btn_lap;
        if (reset) begin
            m_state = S_IDLE;
            m_clr   = 1'b1;
            m_lap   = '0;
            for (int b = 0; b < 3; b++) begin
                m_lvl[b]  = 0;
                m_run[b]  = 0;
                m_tick[b] = 1'b0;
                raw_hist[b].delete();
                raw_hist[b].push_back(1'b0);
                raw_hist[b].push_back(1'b0);
            end
            return;
        end
        // Pick the single winning event among ticks legal in this state.
        m_clr = 1'b0;
        if (m_tick[1] && (m_state == S_IDLE || m_state == S_PAUSE)) win = 1;
        else if (m_tick[0]) win = 2;
        else if (m_tick[2] && (m_state == S_RUN || m_state == S_LAP)) win = 3;
        else win = 0;
        case (win)
            1: begin m_state = S_IDLE; m_clr = 1'b1; end
            2: m_state = (m_state == S_RUN || m_state == S_LAP) ? S_PAUSE : S_RUN;
            3: begin
                if (m_state == S_RUN) begin
                    m_state = S_LAP;
                    m_lap   = {d2_in, d1_in, d0_in};
                end else begin
                    m_state = S_RUN;
                end
            end
            default: ;
        endcase
        // A level is accepted once the 2-cycle-delayed raw value has
        // disagreed with it for DB consecutive edges.
        for (int b = 0; b < 3; b++) begin
            bit d;
            d = raw_hist[b].pop_front();
            raw_hist[b].push_back(raw_now[b]);
            m_tick[b] = 1'b0;
            if (int'(d) != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_lvl[b]  = int'(d);
                    m_run[b]  = 0;
                    m_tick[b] = d;
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit e_go, e_lap;
        logic [11:0] e_disp;
        e_go   = (m_state == S_RUN) || (m_state == S_LAP);
        e_lap  = (m_state == S_LAP);
        e_disp = e_lap ? m_lap : {d2_in, d1_in, d0_in};
        check_eq("state", 32'(dut_state), 32'(m_state));
        check_eq("go", 32'(go), 32'(e_go));
        check_eq("clr", 32'(clr), 32'(m_clr));
        check_eq("lap_active", 32'(lap_active), 32'(e_lap));
        check_eq("disp", 32'({disp_d2, disp_d1, disp_d0}), 32'(e_disp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_digits(input int a, input int b, input int c);
        d2_in = 4'(a);
        d1_in = 4'(b);
        d0_in = 4'(c);
    endtask

    // mask bits: [0]=ss, [1]=clr, [2]=lap
    task automatic press(input bit [2:0] mask, input int hold_n);
        btn_ss  = mask[0];
        btn_clr = mask[1];
        btn_lap = mask[2];
        repeat (hold_n) step();
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        repeat (10) step();
    endtask

    int rem[3];
    int rst_rem;

    initial begin
        reset = 1'b1;
        btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        set_digits(0, 0, 0);

        // Reset held three cycles, then released.
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        // Bouncing start/stop for 20 cycles, then held high.
        for (int i = 0; i < 20; i++) begin
            btn_ss = ((i / 2) % 2 == 0);
            step();
        end
        btn_ss = 1'b1;
        repeat (12) step();
        btn_ss = 1'b0;
        repeat (10) step();

        // Pause, then clear.
        press(3'b001, 8);
        press(3'b010, 8);

        // Lap capture with the live digits moving underneath.
        set_digits(0, 4, 7);
        press(3'b001, 8);
        set_digits(1, 2, 3);
        btn_lap = 1'b1;
        repeat (8) step();
        btn_lap = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            set_digits(1, i / 2, i % 10);
            step();
        end
        set_digits(1, 5, 0);
        repeat (4) step();
        press(3'b010, 8);
        press(3'b100, 8);

        // Clear is ignored in RUN and in LAP.
        press(3'b010, 8);
        press(3'b100, 8);
        press(3'b010, 8);

        // Simultaneous presses: ss+lap in LAP/RUN, then clr+ss in PAUSE.
        press(3'b100, 8);
        press(3'b101, 8);
        press(3'b011, 8);
        press(3'b001, 8);
        press(3'b101, 8);
        press(3'b011, 8);

        // Random traffic with glitches, overlapping presses and resets.
        rst_rem = 0;
        for (int b = 0; b < 3; b++) rem[b] = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (rst_rem == 0 && $urandom_range(0, 399) == 0)
                rst_rem = $urandom_range(1, 3);
            reset = (rst_rem != 0);
            if (rst_rem != 0) rst_rem--;
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    bit lv;
                    lv = 1'($urandom_range(0, 1));
                    rem[b] = $urandom_range(1, 14);
                    case (b)
                        0: btn_ss  = lv;
                        1: btn_clr = lv;
                        default: btn_lap = lv;
                    endcase
                end
                rem[b]--;
            end
            set_digits($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
